// File: rtl/dot_product_engine_pkg.sv
// -----------------------------------------------------------------------------
// dot_product_engine_pkg
//   Shared definitions for the dot-product engine:
//   - clog2 helper for address widths
//   - FSM state encoding (IDLE=0, RUN=1, DRAIN=2, OUT=3)
//   - accumulator width formula (product width plus one bit per address bit,
//     enough headroom for DEPTH worst-case products)
// -----------------------------------------------------------------------------
package dot_product_engine_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_e;

   // Ceiling log2; never returns less than 1 so a single-entry memory still
   // gets a usable one-bit address.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

   // Signed product width plus growth for summing 2**addr_width terms.
   function automatic int acc_width(input int data_width, input int addr_width);
      return (32'sd2 * data_width) + addr_width;
   endfunction

endpackage

// File: rtl/dot_product_engine_mac.sv
// -----------------------------------------------------------------------------
// dot_product_engine_mac
//   Two-stage signed multiply-accumulate.
//   Stage M registers a*b when in_valid is set; stage A adds the sign-extended
//   product into the accumulator.
// Ports
//   clk, rst_n  clock, synchronous active-low reset
//   clear       restart: empties the pipeline and zeroes the accumulator
//   in_valid    a/b carry a valid element pair this cycle
//   last        the pair on a/b is the final one of the vector
//   a, b        signed element operands
//   sum         accumulator value including the product now in stage A
//   done        stage A holds the final product; sum is the finished dot product
// -----------------------------------------------------------------------------
module dot_product_engine_mac #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 21
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic                  last,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  sum,
   output logic                  done
);

   localparam int PW = 2 * DATA_WIDTH;

   logic [PW-1:0]        prod_s;
   logic [PW-1:0]        prod_r;
   logic                 prod_vld_r;
   logic                 prod_last_r;
   logic [ACC_WIDTH-1:0] acc_r;
   logic [ACC_WIDTH-1:0] prod_ext_s;
   logic [ACC_WIDTH-1:0] sum_s;

   // Operands are sign-extended to the product width first so the multiply is
   // evaluated at full precision.
   assign prod_s = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
                   $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});

   assign prod_ext_s = {{(ACC_WIDTH-PW){prod_r[PW-1]}}, prod_r};
   assign sum_s      = acc_r + prod_ext_s;

   // Multiply stage and accumulate stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod_r      <= {PW{1'b0}};
         prod_vld_r  <= 1'b0;
         prod_last_r <= 1'b0;
         acc_r       <= {ACC_WIDTH{1'b0}};
      end else if (clear) begin
         prod_r      <= {PW{1'b0}};
         prod_vld_r  <= 1'b0;
         prod_last_r <= 1'b0;
         acc_r       <= {ACC_WIDTH{1'b0}};
      end else begin
         prod_vld_r  <= in_valid;
         prod_last_r <= in_valid && last;
         if (in_valid) begin
            prod_r <= prod_s;
         end
         if (prod_vld_r) begin
            acc_r <= sum_s;
         end
      end
   end

   assign sum  = sum_s;
   assign done = prod_vld_r && prod_last_r;

endmodule

// File: rtl/dot_product_engine.sv
// -----------------------------------------------------------------------------
// dot_product_engine
//   Streams DEPTH element pairs from two memories (read ports A/B, identical
//   addressing), multiplies each pair and accumulates a signed dot product,
//   then offers it on a valid/ready result interface.
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 pulse, accepted only in IDLE
//   busy                  high from start accept to result handshake
//   rd_en_a/b, rd_addr_a/b read strobes/addresses (A and B always identical)
//   dout_a/b              memory read data, RD_LATENCY cycles after rd_en
//   result, result_valid  dot product, held until result_ready
//   result_ready          consumer handshake
// -----------------------------------------------------------------------------
module dot_product_engine
   import dot_product_engine_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int VETOR_WIDTH = 4,
   parameter int DEPTH       = VETOR_WIDTH * DATA_WIDTH,
   parameter int ADDR_WIDTH  = clog2(DEPTH),
   parameter int RD_LATENCY  = 1,
   parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  rd_en_a,
   output logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [DATA_WIDTH-1:0] dout_a,
   output logic                  rd_en_b,
   output logic [ADDR_WIDTH-1:0] rd_addr_b,
   input  logic [DATA_WIDTH-1:0] dout_b,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  result_valid,
   input  logic                  result_ready
);

   state_e                state_r;
   state_e                state_nx_s;
   logic [ADDR_WIDTH-1:0] rd_addr_r;
   logic                  rd_en_r;
   logic                  busy_r;
   logic                  result_valid_r;
   logic [ACC_WIDTH-1:0]  result_r;
   logic [RD_LATENCY-1:0] vld_r;
   logic [RD_LATENCY-1:0] last_r;
   logic                  start_acc_s;
   logic                  addr_last_s;
   logic                  mac_done_s;
   logic [ACC_WIDTH-1:0]  mac_sum_s;

   assign addr_last_s = (rd_addr_r == ADDR_WIDTH'(DEPTH - 1));
   assign start_acc_s = (state_r == IDLE) && start;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state logic; start outside IDLE falls through unseen.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nx_s = RUN;
            else       state_nx_s = IDLE;
         end
         RUN: begin
            if (addr_last_s) state_nx_s = DRAIN;
            else             state_nx_s = RUN;
         end
         DRAIN: begin
            if (mac_done_s) state_nx_s = OUT;
            else            state_nx_s = DRAIN;
         end
         OUT: begin
            if (result_ready) state_nx_s = IDLE;
            else              state_nx_s = OUT;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // Registered control outputs, address counter and result register.
   // Control flags follow the next state so they change on the same edge as
   // the state itself.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_en_r        <= 1'b0;
         busy_r         <= 1'b0;
         result_valid_r <= 1'b0;
         rd_addr_r      <= {ADDR_WIDTH{1'b0}};
         result_r       <= {ACC_WIDTH{1'b0}};
      end else begin
         rd_en_r        <= (state_nx_s == RUN);
         busy_r         <= (state_nx_s != IDLE);
         result_valid_r <= (state_nx_s == OUT);
         // Counter saturates on the last address instead of wrapping.
         if (state_r == IDLE) begin
            rd_addr_r <= {ADDR_WIDTH{1'b0}};
         end else if ((state_r == RUN) && !addr_last_s) begin
            rd_addr_r <= rd_addr_r + ADDR_WIDTH'(1);
         end
         // The final product is folded in here, so the result appears on the
         // same edge the accumulator would have absorbed it.
         if ((state_r == DRAIN) && mac_done_s) begin
            result_r <= mac_sum_s;
         end
      end
   end

   // Read-valid delay line: tap RD_LATENCY-1 lines up with memory read data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_r  <= {RD_LATENCY{1'b0}};
         last_r <= {RD_LATENCY{1'b0}};
      end else begin
         vld_r[0]  <= rd_en_r;
         last_r[0] <= rd_en_r && addr_last_s;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_r[i]  <= vld_r[i-1];
            last_r[i] <= last_r[i-1];
         end
      end
   end

   dot_product_engine_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (start_acc_s),
      .in_valid (vld_r[RD_LATENCY-1]),
      .last     (last_r[RD_LATENCY-1]),
      .a        (dout_a),
      .b        (dout_b),
      .sum      (mac_sum_s),
      .done     (mac_done_s)
   );

   assign busy         = busy_r;
   assign rd_en_a      = rd_en_r;
   assign rd_en_b      = rd_en_r;
   assign rd_addr_a    = rd_addr_r;
   assign rd_addr_b    = rd_addr_r;
   assign result       = result_r;
   assign result_valid = result_valid_r;

endmodule

// File: tb/tb_dot_product_engine.sv
// -----------------------------------------------------------------------------
// tb_dot_product_engine
//   Directed bench for dot_product_engine with behavioural read memories.
//   u_dut uses RD_LATENCY=1, u_dut2 uses RD_LATENCY=2; both read the same
//   vector contents.
// -----------------------------------------------------------------------------
module tb_dot_product_engine;

   localparam int DW  = 8;
   localparam int AW  = 5;
   localparam int ACW = 21;
   localparam int N   = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, start2 = 1'b0;
   logic          ready = 1'b0, ready2 = 1'b0;
   logic          busy, busy2;
   logic          rd_en_a, rd_en_b, rd_en_a2, rd_en_b2;
   logic [AW-1:0] rd_addr_a, rd_addr_b, rd_addr_a2, rd_addr_b2;
   logic [DW-1:0] dout_a = 8'd0, dout_b = 8'd0;
   logic [DW-1:0] dout_a2 = 8'd0, dout_b2 = 8'd0;
   logic [DW-1:0] pipe_a2 = 8'd0, pipe_b2 = 8'd0;
   logic [ACW-1:0] result, result2;
   logic          result_valid, result_valid2;

   logic [DW-1:0] mem_a [N];
   logic [DW-1:0] mem_b [N];

   int checks = 0;
   int errors = 0;
   int pair_err = 0;
   int addr_q[$];

   always #5 clk = ~clk;

   dot_product_engine u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .dout_a(dout_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .dout_b(dout_b),
      .result(result), .result_valid(result_valid), .result_ready(ready)
   );

   dot_product_engine #(.RD_LATENCY(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2),
      .rd_en_a(rd_en_a2), .rd_addr_a(rd_addr_a2), .dout_a(dout_a2),
      .rd_en_b(rd_en_b2), .rd_addr_b(rd_addr_b2), .dout_b(dout_b2),
      .result(result2), .result_valid(result_valid2), .result_ready(ready2)
   );

   // One-cycle read memories for u_dut.
   always @(posedge clk) begin
      if (rd_en_a) dout_a <= mem_a[rd_addr_a];
      if (rd_en_b) dout_b <= mem_b[rd_addr_b];
   end

   // Two-cycle read memories for u_dut2.
   always @(posedge clk) begin
      if (rd_en_a2) pipe_a2 <= mem_a[rd_addr_a2];
      if (rd_en_b2) pipe_b2 <= mem_b[rd_addr_b2];
      dout_a2 <= pipe_a2;
      dout_b2 <= pipe_b2;
   end

   // Port A/B agreement and issued-address log for u_dut.
   always @(negedge clk) begin
      if ((rd_en_a !== rd_en_b) || (rd_addr_a !== rd_addr_b)) pair_err++;
      if (rd_en_a === 1'b1) addr_q.push_back(int'(rd_addr_a));
   end

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // mode 0: 1*1, 1: i*1, 2: -128*-128, 3: -128*127
   task automatic fill(input int mode);
      for (int i = 0; i < N; i++) begin
         case (mode)
            0:       begin mem_a[i] = 8'd1;      mem_b[i] = 8'd1;    end
            1:       begin mem_a[i] = DW'(i);    mem_b[i] = 8'd1;    end
            2:       begin mem_a[i] = 8'h80;     mem_b[i] = 8'h80;   end
            default: begin mem_a[i] = 8'h80;     mem_b[i] = 8'h7F;   end
         endcase
      end
   endtask

   // Pulse start and count edges from the accept edge to result_valid.
   task automatic run(output int edges);
      addr_q.delete();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      edges = 1;
      while ((edges < 200) && (result_valid !== 1'b1)) begin
         @(posedge clk);
         #1;
         if (result_valid !== 1'b1) edges++;
      end
   endtask

   task automatic handshake(input string tag);
      @(negedge clk) ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_valid_drop"}, 32'(result_valid), 32'sd0);
      chk({tag, "_busy_drop"}, 32'(busy), 32'sd0);
      @(negedge clk) ready = 1'b0;
   endtask

   initial begin
      int lat;
      int bad;
      int n;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'sd0);
      chk("rst_rd_en", 32'(rd_en_a), 32'sd0);
      chk("rst_addr", 32'(rd_addr_a), 32'sd0);
      chk("rst_result", 32'(result), 32'sd0);
      chk("rst_valid", 32'(result_valid), 32'sd0);
      chk("rst_valid2", 32'(result_valid2), 32'sd0);
      rst_n = 1'b1;

      // 1: all ones.
      fill(0);
      run(lat);
      chk("t1_latency", lat, 32'sd34);
      chk("t1_result", $signed(result), 32'sd32);
      chk("t1_addr_count", addr_q.size(), 32'sd32);
      bad = 0;
      foreach (addr_q[i]) if (addr_q[i] != i) bad++;
      chk("t1_addr_order", bad, 32'sd0);
      chk("t1_busy", 32'(busy), 32'sd1);
      handshake("t1");

      // 2: ramp times one.
      fill(1);
      run(lat);
      chk("t2_result", $signed(result), 32'sd496);
      chk("t2_ab_match", pair_err, 32'sd0);
      handshake("t2");

      // 3: sign extension corners.
      fill(2);
      run(lat);
      chk("t3_neg_neg", $signed(result), 32'sd524288);
      handshake("t3a");
      fill(3);
      run(lat);
      chk("t3_neg_pos", $signed(result), -32'sd520192);
      handshake("t3b");

      // 4: back-pressure with stray start pulses.
      fill(1);
      run(lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = ((i == 3) || (i == 6)) ? 1'b1 : 1'b0;
         chk("t4_hold_result", $signed(result), 32'sd496);
         chk("t4_hold_valid", 32'(result_valid), 32'sd1);
         chk("t4_hold_busy", 32'(busy), 32'sd1);
      end
      @(negedge clk) begin ready = 1'b1; start = 1'b1; end
      @(posedge clk);
      #1;
      chk("t4_valid_drop", 32'(result_valid), 32'sd0);
      chk("t4_busy_drop", 32'(busy), 32'sd0);
      @(negedge clk) begin ready = 1'b0; start = 1'b0; end
      repeat (3) @(negedge clk);
      chk("t4_no_queued_start", 32'(busy), 32'sd0);
      chk("t4_no_read", 32'(rd_en_a), 32'sd0);

      // 5: reset mid-run, then a clean run.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while ((rd_addr_a !== 5'd10) && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reach_addr10", 32'(rd_addr_a), 32'sd10);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_rd_en", 32'(rd_en_a), 32'sd0);
      chk("t5_busy", 32'(busy), 32'sd0);
      chk("t5_valid", 32'(result_valid), 32'sd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("t5_no_partial", 32'(result_valid), 32'sd0);
      run(lat);
      chk("t5_rerun_latency", lat, 32'sd34);
      chk("t5_rerun_result", $signed(result), 32'sd496);
      handshake("t5");

      // 6: two-cycle read latency build.
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      lat = 1;
      while ((lat < 200) && (result_valid2 !== 1'b1)) begin
         @(posedge clk);
         #1;
         if (result_valid2 !== 1'b1) lat++;
      end
      chk("t6_latency", lat, 32'sd35);
      chk("t6_result", $signed(result2), 32'sd496);
      @(negedge clk) ready2 = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_valid_drop", 32'(result_valid2), 32'sd0);
      chk("t6_busy_drop", 32'(busy2), 32'sd0);
      @(negedge clk) ready2 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
